mmp_iddmm_sp: RTL and testbench

- Word-serial Montgomery modular multiplier (iterative digit-digit Montgomery, single-port task interface).
- Computes res = X·Y·R⁻¹ mod M, with R = 2^(K·N), over N words of K bits.
- The modular-exponentiation controller loads X/Y word by word, requests a task, then collects the N result words low-first.

---
 rtl/mmp_iddmm_sp.sv | 190 +++++++++++++++++++
 tb/tb_mmp_iddmm_sp.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mmp_iddmm_sp.sv
// Word-serial Montgomery multiplier: res = X*Y*R^-1 mod M, R = 2^(K*N).
// Optional macro MMP_WR_M_EN makes the M RAM writable through wr_m.
module mmp_iddmm_sp #(
    parameter string MULT_METHOD = "COMMON",
    parameter string ADD1_METHOD = "COMMON",
    parameter string ADD2_METHOD = "COMMON",
    parameter int MULT_LATENCY = 0,
    parameter int ADD1_LATENCY = 0,
    parameter int K = 128,
    parameter int N = 16,
    parameter int ADDR_W = $clog2(N),
    parameter logic [K*N-1:0] M_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        wr_ena,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [K-1:0]      wr_x,
    input  logic [K-1:0]      wr_y,
    input  logic [K-1:0]      wr_m,
    input  logic [K-1:0]      wr_m1,
    input  logic              task_req,
    output logic              task_end,
    output logic              task_grant,
    output logic [K-1:0]      task_res
);

    localparam int L  = 1 + MULT_LATENCY + ADD1_LATENCY;
    localparam int LW = $clog2(L + 1);
    localparam int CW = $clog2(N + 2);
    localparam int K2 = 2 * K;
    localparam int K3 = K + 2;

    typedef enum logic [2:0] {IDLE, MUL, SUB, OUT, END} state_t;

    state_t state, next;

    logic [K-1:0] x_ram [2**ADDR_W];
    logic [K-1:0] y_ram [2**ADDR_W];
    logic [K-1:0] d     [2**ADDR_W];
    logic [K-1:0] t     [2**CW];
    logic [N*K-1:0] m_vec;

    logic [K-1:0]  q, m1, c1, c2;
    logic          borrow;
    logic [CW-1:0] i, j, w;
    logic [LW-1:0] lat;

    logic [ADDR_W-1:0] ia, ja, wa;
    logic [K-1:0]  yi, xw, mw, mj, t0s, qn;
    logic [K2-1:0] s, u;
    logic [K3-1:0] top;
    logic [K:0]    diff;
    logic          step, use_d;

`ifdef MMP_WR_M_EN
    logic [N*K-1:0] m_reg = M_INIT;

    // M RAM shares the X write strobe
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_ena[0])
            m_reg[int'(wr_addr)*K +: K] <= wr_m;
    end

    assign m_vec = m_reg;
`else
    logic m_unused;

    assign m_unused = ^wr_m;
    assign m_vec    = M_INIT;
`endif

    assign w   = j - CW'(1);
    assign ia  = i[ADDR_W-1:0];
    assign ja  = j[ADDR_W-1:0];
    assign wa  = w[ADDR_W-1:0];
    assign yi  = y_ram[ia];
    assign xw  = x_ram[wa];
    assign mw  = m_vec[int'(wa)*K +: K];
    assign mj  = m_vec[int'(ja)*K +: K];
    assign t0s = t[0] + x_ram[0] * yi;
    assign qn  = t0s * m1;
    assign s   = K2'(t[w]) + K2'(xw) * K2'(yi) + K2'(c1);
    assign u   = K2'(s[K-1:0]) + K2'(q) * K2'(mw) + K2'(c2);
    assign top = K3'(t[CW'(N)]) + K3'(c1) + K3'(c2);
    assign diff = {1'b0, t[j]} - {1'b0, mj} - {{K{1'b0}}, borrow};
    assign step = (lat == LW'(L - 1));
    assign use_d = (t[CW'(N)] != '0) || !borrow;

    // Operand RAMs accept writes only while idle
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (wr_ena[0]) x_ram[wr_addr] <= wr_x;
            if (wr_ena[1]) y_ram[wr_addr] <= wr_y;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= next;
    end

    // Next-state logic
    always_comb begin
        next = state;
        unique case (state)
            IDLE: if (task_req) next = MUL;
            MUL:  if (step && j == CW'(N + 1) && i == CW'(N - 1))
                      next = SUB;
            SUB:  if (j == CW'(N - 1)) next = OUT;
            OUT:  if (j == CW'(N - 1)) next = END;
            END:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Fused multiply/reduce loop, final subtraction and word counters
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2**CW; k++) t[k] <= '0;
            i      <= '0;
            j      <= '0;
            lat    <= '0;
            c1     <= '0;
            c2     <= '0;
            borrow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (task_req) begin
                        for (int k = 0; k < 2**CW; k++) t[k] <= '0;
                        m1  <= wr_m1;
                        i   <= '0;
                        j   <= '0;
                        lat <= '0;
                    end
                end
                MUL: begin
                    if (!step) begin
                        lat <= lat + LW'(1);
                    end else begin
                        lat <= '0;
                        if (j == '0) begin
                            q  <= qn;
                            c1 <= '0;
                            c2 <= '0;
                            j  <= CW'(1);
                        end else if (j <= CW'(N)) begin
                            if (j != CW'(1)) t[w - CW'(1)] <= u[K-1:0];
                            c1 <= s[K2-1:K];
                            c2 <= u[K2-1:K];
                            j  <= j + CW'(1);
                        end else begin
                            t[CW'(N - 1)] <= top[K-1:0];
                            t[CW'(N)]     <= K'(top[K3-1:K]);
                            j      <= '0;
                            borrow <= 1'b0;
                            i <= (i == CW'(N - 1)) ? '0 : i + CW'(1);
                        end
                    end
                end
                SUB: begin
                    d[ja]  <= diff[K-1:0];
                    borrow <= diff[K];
                    j <= (j == CW'(N - 1)) ? '0 : j + CW'(1);
                end
                OUT: begin
                    j <= (j == CW'(N - 1)) ? '0 : j + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered result port; task_res holds between tasks
    always_ff @(posedge clk) begin
        if (rst_n) begin
            task_grant <= 1'b0;
            task_end   <= 1'b0;
            task_res   <= '0;
        end else begin
            task_grant <= (state == OUT);
            task_end   <= (state == END);
            if (state == OUT)
                task_res <= use_d ? d[ja] : t[j];
        end
    end

endmodule

// File: tb/tb_mmp_iddmm_sp.sv
// Directed bench for mmp_iddmm_sp with K=8, N=2, M=251.
// Table-driven vectors plus reset-abort and back-to-back sequences.
module tb_mmp_iddmm_sp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] wr_ena = '0;
    logic [0:0] wr_addr = '0;
    logic [7:0] wr_x = '0;
    logic [7:0] wr_y = '0;
    logic [7:0] wr_m = '0;
    logic [7:0] wr_m1 = 8'hCD;
    logic       task_req = 1'b0;
    logic       task_end;
    logic       task_grant;
    logic [7:0] task_res;

    logic [15:0] m_cur = 16'h00FB;
    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] res;
    } vec_t;

    vec_t vecs [7];

    mmp_iddmm_sp #(
        .K(8),
        .N(2),
        .M_INIT(16'h00FB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_ena(wr_ena),
        .wr_addr(wr_addr),
        .wr_x(wr_x),
        .wr_y(wr_y),
        .wr_m(wr_m),
        .wr_m1(wr_m1),
        .task_req(task_req),
        .task_end(task_end),
        .task_grant(task_grant),
        .task_res(task_res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        wr_ena = 2'b11; wr_addr = 1'b0;
        wr_x = x[7:0]; wr_y = y[7:0]; wr_m = m_cur[7:0];
        @(negedge clk);
        wr_addr = 1'b1;
        wr_x = x[15:8]; wr_y = y[15:8]; wr_m = m_cur[15:8];
        @(negedge clk);
        wr_ena = 2'b00;
    endtask

    task automatic run(input string nm, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] exp);
        int cnt;
        logic [7:0] lo, hi;
        load(x, y);
        task_req = 1'b1;
        @(posedge clk);
        #1 task_req = 1'b0;
        cnt = 0;
        while (!task_grant && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({nm, " latency"}, cnt, 11);
        lo = task_res;
        chk({nm, " end_early"}, int'(task_end), 0);
        @(posedge clk);
        #1;
        chk({nm, " grant1"}, int'(task_grant), 1);
        hi = task_res;
        chk({nm, " result"}, int'({hi, lo}), int'(exp));
        @(posedge clk);
        #1;
        chk({nm, " grant_off"}, int'(task_grant), 0);
        chk({nm, " end"}, int'(task_end), 1);
        @(posedge clk);
        #1;
        chk({nm, " end_off"}, int'(task_end), 0);
        chk({nm, " hold"}, int'(task_res), int'(exp[15:8]));
    endtask

    initial begin
        int g;
        logic [7:0] wq [4];

        vecs[0] = '{"to_mont",   16'd25,  16'd100, 16'd100};
        vecs[1] = '{"r2",        16'd123, 16'd1,   16'd25};
        vecs[2] = '{"one",       16'd25,  16'd1,   16'd1};
        vecs[3] = '{"zero",      16'd0,   16'd200, 16'd0};
        vecs[4] = '{"neg_sq",    16'd250, 16'd250, 16'd241};
        vecs[5] = '{"r2_sq",     16'd123, 16'd123, 16'd63};
        vecs[6] = '{"neg_one",   16'd250, 16'd1,   16'd10};

        repeat (3) @(posedge clk);
        #1;
        chk("rst grant", int'(task_grant), 0);
        chk("rst end", int'(task_end), 0);
        chk("rst res", int'(task_res), 0);
        @(negedge clk);
        rst_n = 1'b0;

        for (int v = 0; v < 7; v++)
            run(vecs[v].name, vecs[v].x, vecs[v].y, vecs[v].res);

        load(16'd25, 16'd100);
        task_req = 1'b1;
        @(posedge clk);
        #1 task_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort grant", int'(task_grant), 0);
        chk("abort end", int'(task_end), 0);
        chk("abort res", int'(task_res), 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        g = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (task_grant || task_end) g++;
        end
        chk("abort quiet", g, 0);
        run("post_rst", 16'd25, 16'd100, 16'd100);

        load(16'd123, 16'd1);
        task_req = 1'b1;
        @(posedge clk);
        g = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (task_grant) begin
                if (g < 4) wq[g] = task_res;
                g++;
            end
        end
        task_req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("restart grants", g, 4);
        chk("restart lo", int'(wq[2]), 25);
        chk("restart hi", int'(wq[3]), 0);
        chk("restart idle", int'(task_grant), 0);

`ifdef MMP_WR_M_EN
        m_cur = 16'h00F1;
        wr_m1 = 8'hEF;
        run("wr_m", 16'd225, 16'd77, 16'd77);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
